// File: rtl/fetch_align_buffer_pkg.sv
// Shared types, constants and helpers for the fetch-to-decode align buffer.
package fetch_align_buffer_pkg;

  localparam int fab_depth_hw = 8;
  localparam int fab_fetch_hw = 2;
  localparam logic [3:0] except_instr_access_fault = 4'd1;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } fab_entry_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        error;
  } fetch_align_in_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } fetch_align_out_type;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_storage.sv
// Halfword entry array: one multi-halfword write port, two-entry read at rptr/rptr+1.
module fab_storage
  import fetch_align_buffer_pkg::*;
#(
  parameter int FETCH_HW = fab_fetch_hw,
  parameter int DEPTH_HW = fab_depth_hw,
  parameter int AW       = $clog2(DEPTH_HW),
  parameter int SKW      = $clog2(FETCH_HW)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           wptr,
  input  logic [SKW-1:0]          skip,
  input  logic [16*FETCH_HW-1:0]  wdata,
  input  logic                    werr,
  input  logic [AW-1:0]           rptr,
  output fab_entry_type           rd0,
  output fab_entry_type           rd1
);

  fab_entry_type mem [DEPTH_HW];

  logic [FETCH_HW-1:0]         wen;
  logic [FETCH_HW-1:0][AW-1:0] widx;

  // Leading 'skip' halfwords are dropped; the rest pack from wptr upward.
  for (genvar i = 0; i < FETCH_HW; i++) begin : g_wr
    assign wen[i]  = we & (AW'(i) >= AW'(skip));
    assign widx[i] = wptr + AW'(i) - AW'(skip);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_HW; i++)
      if (wen[i]) mem[widx[i]] <= '{hw: wdata[i*16 +: 16], err: werr};
  end

  assign rd0 = mem[rptr];
  assign rd1 = mem[rptr + AW'(1)];

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch-to-decode halfword queue that realigns RVC and straddling 32-bit instructions.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FETCH_HW = fab_fetch_hw,
  parameter int DEPTH_HW = fab_depth_hw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_valid,
  output logic                   f_ready,
  input  logic [XLEN-1:0]        f_pc,
  input  logic [16*FETCH_HW-1:0] f_rdata,
  input  logic                   f_error,
  input  logic                   flush,
  input  logic [XLEN-1:0]        flush_pc,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [XLEN-1:0]        d_pc,
  output logic [XLEN-1:0]        d_npc,
  output logic [31:0]            d_instr,
  output logic                   d_exception,
  output logic [3:0]             d_ecause,
  output logic [XLEN-1:0]        d_etval
);

  localparam int AW  = $clog2(DEPTH_HW);
  localparam int CW  = AW + 1;
  localparam int SKW = $clog2(FETCH_HW);
  localparam int OW  = $clog2(2*FETCH_HW);

  logic [CW-1:0]   count;
  logic [AW-1:0]   rptr, wptr;
  logic [SKW-1:0]  skip;
  logic [XLEN-1:0] exp_pc, head_pc;

  fab_entry_type head_e, nxt_e;
  logic          accept, is32, fault, pop_two;
  logic [CW-1:0] push_n, pop_n;

  fab_storage #(.FETCH_HW(FETCH_HW), .DEPTH_HW(DEPTH_HW)) u_storage (
    .clk   (clk),
    .we    (accept),
    .wptr  (wptr),
    .skip  (skip),
    .wdata (f_rdata),
    .werr  (f_error),
    .rptr  (rptr),
    .rd0   (head_e),
    .rd1   (nxt_e)
  );

  // Stale words from before a redirect show up with the wrong pc and are dropped.
  assign f_ready = count <= CW'(DEPTH_HW - FETCH_HW);
  assign accept  = f_valid & f_ready & ~flush & (f_pc == exp_pc);
  assign push_n  = accept ? CW'(FETCH_HW) - CW'(skip) : '0;

  always_comb begin
    is32    = ~is_compressed(head_e.hw);
    fault   = head_e.err | (is32 & nxt_e.err);
    pop_two = is32 & ~head_e.err;
    // A faulting lower half is presented alone; its upper half may never come.
    d_valid = (count != '0) & (~is32 | head_e.err | (count >= CW'(2)));
    d_pc        = '0;
    d_npc       = '0;
    d_instr     = '0;
    d_exception = 1'b0;
    d_ecause    = '0;
    d_etval     = '0;
    if (d_valid) begin
      d_pc        = head_pc;
      d_npc       = head_pc + (is32 ? XLEN'(4) : XLEN'(2));
      d_instr     = is32 ? {nxt_e.hw, head_e.hw} : {16'h0, head_e.hw};
      d_exception = fault;
      if (fault) begin
        d_ecause = except_instr_access_fault;
        d_etval  = head_e.err ? head_pc : head_pc + XLEN'(2);
      end
    end
    pop_n = (d_valid & d_ready) ? (pop_two ? CW'(2) : CW'(1)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      rptr    <= '0;
      wptr    <= '0;
      skip    <= '0;
      exp_pc  <= '0;
      head_pc <= '0;
    end else if (flush) begin
      count   <= '0;
      rptr    <= '0;
      wptr    <= '0;
      skip    <= flush_pc[OW-1:1];
      exp_pc  <= flush_pc & ~XLEN'(2*FETCH_HW - 1);
      head_pc <= flush_pc;
    end else begin
      count   <= count + push_n - pop_n;
      wptr    <= wptr + AW'(push_n);
      rptr    <= rptr + AW'(pop_n);
      head_pc <= head_pc + XLEN'({pop_n, 1'b0});
      if (accept) begin
        exp_pc <= exp_pc + XLEN'(2*FETCH_HW);
        skip   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer (XLEN=32, FETCH_HW=2, DEPTH_HW=8).
module tb_fetch_align_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid, f_ready, f_error, flush, d_valid, d_ready, d_exception;
  logic [31:0] f_pc, f_rdata, flush_pc, d_pc, d_npc, d_instr, d_etval;
  logic [3:0]  d_ecause;

  int total = 0;
  int bad   = 0;

  fetch_align_buffer #(.XLEN(32), .FETCH_HW(2), .DEPTH_HW(8)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc),
    .f_rdata(f_rdata), .f_error(f_error), .flush(flush), .flush_pc(flush_pc),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_npc(d_npc),
    .d_instr(d_instr), .d_exception(d_exception), .d_ecause(d_ecause), .d_etval(d_etval)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] data, input logic err);
    f_valid = 1'b1; f_pc = pc; f_rdata = data; f_error = err;
    tick();
    f_valid = 1'b0; f_error = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush = 1'b1; flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [32*4+3+4:0] act, exp_v;
    act   = {f_ready, d_valid, d_exception, d_pc, d_npc, d_instr, d_etval, d_ecause};
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0};
    total++;
    if (act !== exp_v) begin bad++; $display("FAIL reset_state act=%h exp=%h", act, exp_v); end
    d_ready = 1'b0;
    push_word(32'h0, 32'h00A0_0513, 1'b0);
    total++;
    if (d_valid !== 1'b1) begin bad++; $display("FAIL reset_prefill d_valid act=%b exp=1", d_valid); end
    rst = 1'b1;
    #1;
    total++;
    if ({d_valid, f_ready} !== 2'b01) begin bad++; $display("FAIL reset_async act=%b exp=01", {d_valid, f_ready}); end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({d_valid, f_ready, d_pc} !== {2'b01, 32'h0}) begin
      bad++; $display("FAIL reset_after act=%b/%b/%h exp=0/1/0", d_valid, f_ready, d_pc);
    end
  endtask

  task automatic test_single();
    d_ready = 1'b0;
    push_word(32'h0, 32'h00A0_0513, 1'b0);
    total++;
    if ({d_valid, d_pc, d_npc, d_instr, d_exception} !== {1'b1, 32'h0, 32'h4, 32'h00A0_0513, 1'b0}) begin
      bad++; $display("FAIL single act=%b pc=%h npc=%h instr=%h exc=%b exp=1 0 4 00a00513 0",
                      d_valid, d_pc, d_npc, d_instr, d_exception);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL single_drain d_valid act=%b exp=0", d_valid); end
  endtask

  task automatic test_straddle();
    flush_to(32'h0);
    d_ready = 1'b0;
    push_word(32'h0, 32'h1237_4505, 1'b0);
    total++;
    if ({d_valid, d_pc, d_npc, d_instr} !== {1'b1, 32'h0, 32'h2, 32'h0000_4505}) begin
      bad++; $display("FAIL strad_c act pc=%h npc=%h instr=%h exp=0 2 00004505", d_pc, d_npc, d_instr);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL strad_wait_upper d_valid act=%b exp=0", d_valid); end
    push_word(32'h4, 32'hABCD_0001, 1'b0);
    total++;
    if ({d_valid, d_pc, d_npc, d_instr} !== {1'b1, 32'h2, 32'h6, 32'h0001_1237}) begin
      bad++; $display("FAIL strad_32 act pc=%h npc=%h instr=%h exp=2 6 00011237", d_pc, d_npc, d_instr);
    end
    d_ready = 1'b1;
    tick();
    total++;
    if ({d_valid, d_pc, d_npc, d_instr} !== {1'b1, 32'h6, 32'h8, 32'h0000_ABCD}) begin
      bad++; $display("FAIL strad_tail act pc=%h npc=%h instr=%h exp=6 8 0000abcd", d_pc, d_npc, d_instr);
    end
    tick();
    d_ready = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL strad_empty d_valid act=%b exp=0", d_valid); end
  endtask

  task automatic test_full();
    logic [15:0] h0, h1;
    flush_to(32'h0);
    d_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (f_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d act=%b exp=1", k, f_ready); end
      h0 = 16'h1001 + 16'((2*k) << 4);
      h1 = 16'h1001 + 16'((2*k+1) << 4);
      push_word(32'(4*k), {h1, h0}, 1'b0);
    end
    total++;
    if (f_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready act=%b exp=0", f_ready); end
    push_word(32'h10, 32'hDEAD_BEEF, 1'b0);
    d_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      h0 = 16'h1001 + 16'(j << 4);
      total++;
      if ({d_valid, d_pc, d_instr} !== {1'b1, 32'(2*j), 16'h0, h0}) begin
        bad++; $display("FAIL full_drain_%0d act v=%b pc=%h instr=%h exp pc=%h instr=%h",
                        j, d_valid, d_pc, d_instr, 32'(2*j), h0);
      end
      tick();
    end
    d_ready = 1'b0;
    total++;
    if ({d_valid, f_ready} !== 2'b01) begin bad++; $display("FAIL full_after act=%b exp=01", {d_valid, f_ready}); end
  endtask

  task automatic test_flush();
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h8; f_rdata = 32'h1111_1111;
    flush_to(32'h102);
    f_valid = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL flush_drop d_valid act=%b exp=0", d_valid); end
    push_word(32'h104, 32'h3333_3333, 1'b0);
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL flush_stale d_valid act=%b exp=0", d_valid); end
    push_word(32'h100, 32'h5551_1111, 1'b0);
    total++;
    if ({d_valid, d_pc, d_npc, d_instr} !== {1'b1, 32'h102, 32'h104, 32'h0000_5551}) begin
      bad++; $display("FAIL flush_skip act pc=%h npc=%h instr=%h exp=102 104 00005551", d_pc, d_npc, d_instr);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL flush_empty d_valid act=%b exp=0", d_valid); end
  endtask

  task automatic test_fault();
    flush_to(32'h1E);
    d_ready = 1'b0;
    push_word(32'h1C, 32'h00B3_FFFF, 1'b0);
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL fault_wait d_valid act=%b exp=0", d_valid); end
    push_word(32'h20, 32'h0000_0040, 1'b1);
    total++;
    if ({d_valid, d_pc, d_npc, d_exception, d_ecause, d_etval} !==
        {1'b1, 32'h1E, 32'h22, 1'b1, 4'd1, 32'h20}) begin
      bad++; $display("FAIL fault_upper act v=%b pc=%h npc=%h exc=%b cause=%h tval=%h exp=1 1e 22 1 1 20",
                      d_valid, d_pc, d_npc, d_exception, d_ecause, d_etval);
    end
    d_ready = 1'b1;
    tick();
    total++;
    if ({d_valid, d_pc, d_exception, d_etval} !== {1'b1, 32'h22, 1'b1, 32'h22}) begin
      bad++; $display("FAIL fault_next act v=%b pc=%h exc=%b tval=%h exp=1 22 1 22",
                      d_valid, d_pc, d_exception, d_etval);
    end
    tick();
    d_ready = 1'b0;
    total++;
    if ({d_valid, d_exception} !== 2'b00) begin bad++; $display("FAIL fault_empty act=%b exp=00", {d_valid, d_exception}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] h;
    flush_to(32'h40);
    d_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        f_valid = 1'b1; f_pc = 32'h40 + 32'(4*c);
        f_rdata = {16'h2001 + 16'((2*c+1) << 4), 16'h2001 + 16'((2*c) << 4)};
      end else begin
        f_valid = 1'b0;
      end
      tick();
      h = 16'h2001 + 16'(c << 4);
      total++;
      if ({d_valid, d_pc, d_instr} !== {1'b1, 32'h40 + 32'(2*c), 16'h0, h}) begin
        bad++; $display("FAIL b2b_%0d act v=%b pc=%h instr=%h exp pc=%h instr=%h",
                        c, d_valid, d_pc, d_instr, 32'h40 + 32'(2*c), h);
      end
    end
    f_valid = 1'b0;
    tick();
    d_ready = 1'b0;
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty d_valid act=%b exp=0", d_valid); end
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b0; f_pc = '0; f_rdata = '0; f_error = 1'b0;
    flush = 1'b0; flush_pc = '0; d_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_straddle();
    test_full();
    test_flush();
    test_fault();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
